wishbone_rr_arbiter: RTL and testbench

- Shares one Wishbone slave port between two Wishbone masters, e.g. the instruction-side and data-side AHB-to-Wishbone bridges of a core, feeding a single memory or peripheral bus.
- Grants are round-robin and are held for the whole master cycle (cyc high), so bursts are not interleaved.
- A per-grant watchdog aborts a cycle the slave never acknowledges and reports it to the owning master as an error.

---
 rtl/wishbone_rr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_wishbone_rr_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/wishbone_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wishbone_rr_arbiter
// Shares one Wishbone slave port between two Wishbone masters. Ownership is
// granted round-robin and held for the whole master cycle (cyc high), so
// bursts never interleave. A per-grant watchdog aborts a strobe the slave
// never acknowledges and reports it to the owning master as a one-cycle err.
//
// Ports:
//   HCLK, HRESETn          clock (rising edge), async active-low reset
//   m0_* / m1_*            master ports: cyc, stb, we, adr, dat_w in;
//                          dat_r, ack, err out
//   s_*                    slave port: cyc, stb, we, adr, dat_w out;
//                          dat_r, ack in
//   grant                  one-hot owner (bit0 = m0, bit1 = m1), 00 when idle
// ---------------------------------------------------------------------------
module wishbone_rr_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,

    input  logic                  m0_cyc,
    input  logic                  m0_stb,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_adr,
    input  logic [DATA_WIDTH-1:0] m0_dat_w,
    output logic [DATA_WIDTH-1:0] m0_dat_r,
    output logic                  m0_ack,
    output logic                  m0_err,

    input  logic                  m1_cyc,
    input  logic                  m1_stb,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_adr,
    input  logic [DATA_WIDTH-1:0] m1_dat_w,
    output logic [DATA_WIDTH-1:0] m1_dat_r,
    output logic                  m1_ack,
    output logic                  m1_err,

    output logic                  s_cyc,
    output logic                  s_stb,
    output logic                  s_we,
    output logic [ADDR_WIDTH-1:0] s_adr,
    output logic [DATA_WIDTH-1:0] s_dat_w,
    input  logic [DATA_WIDTH-1:0] s_dat_r,
    input  logic                  s_ack,

    output logic [1:0]            grant
);

    localparam bit          WD_EN = (TIMEOUT_CYCLES != 0);
    localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            last;        // 0: m0 granted most recently, 1: m1
    logic [WD_W-1:0] wd_cnt;

    logic own_cyc;
    logic own_stb;
    logic stb_pend;
    logic abort;

    // State register, round-robin history and watchdog counter
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state  <= IDLE;
            last   <= 1'b1;
            wd_cnt <= '0;
        end else begin
            state <= next_state;

            if (next_state != state) begin
                if (next_state == GNT0) last <= 1'b0;
                else if (next_state == GNT1) last <= 1'b1;
            end

            // Any ownership change, ack or abort restarts the timeout window
            if (!WD_EN || next_state != state || state == IDLE) begin
                wd_cnt <= '0;
            end else if (s_ack || abort) begin
                wd_cnt <= '0;
            end else if (s_stb && wd_cnt < WD_LIMIT) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
        end
    end

    // Next-state: arbitrate from IDLE, hand over directly on release
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (m0_cyc && (!m1_cyc || last)) next_state = GNT0;
                else if (m1_cyc)                 next_state = GNT1;
            end
            GNT0: begin
                if (!m0_cyc) next_state = m1_cyc ? GNT1 : IDLE;
            end
            GNT1: begin
                if (!m1_cyc) next_state = m0_cyc ? GNT0 : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Slave-side mux from the current owner
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        s_we    = 1'b0;
        s_adr   = m0_adr;
        s_dat_w = m0_dat_w;
        case (state)
            GNT0: begin
                own_cyc = m0_cyc;
                own_stb = m0_stb;
                s_we    = m0_we;
                s_adr   = m0_adr;
                s_dat_w = m0_dat_w;
            end
            GNT1: begin
                own_cyc = m1_cyc;
                own_stb = m1_stb;
                s_we    = m1_we;
                s_adr   = m1_adr;
                s_dat_w = m1_dat_w;
            end
            default: ;
        endcase
    end

    // A strobe gated by its own cyc is never forwarded during the release cycle.
    // An ack arriving on the limit cycle beats the abort.
    assign stb_pend = own_cyc & own_stb;
    assign abort    = WD_EN && (wd_cnt == WD_LIMIT) && stb_pend && !s_ack;

    assign s_cyc = own_cyc  & ~abort;
    assign s_stb = stb_pend & ~abort;

    assign m0_ack = (state == GNT0) & s_ack;
    assign m1_ack = (state == GNT1) & s_ack;
    assign m0_err = (state == GNT0) & abort;
    assign m1_err = (state == GNT1) & abort;

    // Read data is qualified by ack, so both masters see the slave bus
    assign m0_dat_r = s_dat_r;
    assign m1_dat_r = s_dat_r;

    assign grant = {state == GNT1, state == GNT0};

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wishbone_rr_arbiter
// Directed cycle-by-cycle bench for wishbone_rr_arbiter with TIMEOUT_CYCLES=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Expected values are written by hand in each vector.
// ---------------------------------------------------------------------------
module tb_wishbone_rr_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        m0_cyc, m0_stb, m0_we;
    logic [31:0] m0_adr, m0_dat_w, m0_dat_r;
    logic        m0_ack, m0_err;
    logic        m1_cyc, m1_stb, m1_we;
    logic [31:0] m1_adr, m1_dat_w, m1_dat_r;
    logic        m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_dat_w, s_dat_r;
    logic        s_ack;
    logic [1:0]  grant;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] rd_val   = 32'hDA7A_0000;

    always #5 HCLK = ~HCLK;

    wishbone_rr_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .m0_cyc   (m0_cyc),
        .m0_stb   (m0_stb),
        .m0_we    (m0_we),
        .m0_adr   (m0_adr),
        .m0_dat_w (m0_dat_w),
        .m0_dat_r (m0_dat_r),
        .m0_ack   (m0_ack),
        .m0_err   (m0_err),
        .m1_cyc   (m1_cyc),
        .m1_stb   (m1_stb),
        .m1_we    (m1_we),
        .m1_adr   (m1_adr),
        .m1_dat_w (m1_dat_w),
        .m1_dat_r (m1_dat_r),
        .m1_ack   (m1_ack),
        .m1_err   (m1_err),
        .s_cyc    (s_cyc),
        .s_stb    (s_stb),
        .s_we     (s_we),
        .s_adr    (s_adr),
        .s_dat_w  (s_dat_w),
        .s_dat_r  (s_dat_r),
        .s_ack    (s_ack),
        .grant    (grant)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // One bus cycle: req = {m1_cyc, m1_stb, m0_cyc, m0_stb}; e_ack/e_err = {m1, m0}
    task automatic cyc_vec(input string tag, input logic [3:0] req, input logic ack,
                           input logic [1:0] e_gnt, input logic e_cyc, input logic [31:0] e_adr,
                           input logic [1:0] e_ack, input logic [1:0] e_err);
        @(posedge HCLK);
        #1;
        {m1_cyc, m1_stb, m0_cyc, m0_stb} = req;
        s_ack   = ack;
        rd_val  = rd_val + 32'h11;
        s_dat_r = rd_val;
        @(negedge HCLK);
        chk({tag, ".grant"}, 64'(grant), 64'(e_gnt));
        chk({tag, ".s_cyc"}, 64'(s_cyc), 64'(e_cyc));
        chk({tag, ".s_stb"}, 64'(s_stb), 64'(e_cyc));
        chk({tag, ".ack"},   64'({m1_ack, m0_ack}), 64'(e_ack));
        chk({tag, ".err"},   64'({m1_err, m0_err}), 64'(e_err));
        if (e_cyc)    chk({tag, ".s_adr"},    64'(s_adr),    64'(e_adr));
        if (e_ack[0]) chk({tag, ".m0_dat_r"}, 64'(m0_dat_r), 64'(rd_val));
        if (e_ack[1]) chk({tag, ".m1_dat_r"}, 64'(m1_dat_r), 64'(rd_val));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        HRESETn  = 1'b0;
        m0_cyc   = 1'b1; m0_stb = 1'b1; m0_we = 1'b0;
        m0_adr   = 32'h0000_00A0; m0_dat_w = 32'hCAFE_0000;
        m1_cyc   = 1'b1; m1_stb = 1'b1; m1_we = 1'b0;
        m1_adr   = 32'h0000_00B0; m1_dat_w = 32'hBEEF_0000;
        s_ack    = 1'b1;
        s_dat_r  = 32'h0;

        // Reset with both masters requesting and a stray slave ack
        #22;
        @(negedge HCLK);
        chk("rst.grant", 64'(grant), 64'h0);
        chk("rst.s_cyc", 64'(s_cyc), 64'h0);
        chk("rst.s_stb", 64'(s_stb), 64'h0);
        chk("rst.ack",   64'({m1_ack, m0_ack}), 64'h0);
        chk("rst.err",   64'({m1_err, m0_err}), 64'h0);
        s_ack   = 1'b0;
        HRESETn = 1'b1;
        #1;
        chk("rel.grant", 64'(grant), 64'h0);

        // Contention: alternating single reads, ack the cycle after stb
        cyc_vec("c1",  4'b1111, 1'b0, 2'b01, 1'b1, 32'hA0, 2'b00, 2'b00);
        cyc_vec("c2",  4'b1111, 1'b1, 2'b01, 1'b1, 32'hA0, 2'b01, 2'b00);
        m0_adr = 32'h0000_00A4;
        cyc_vec("c3",  4'b1100, 1'b0, 2'b01, 1'b0, 32'h0,  2'b00, 2'b00);
        cyc_vec("c4",  4'b1111, 1'b0, 2'b10, 1'b1, 32'hB0, 2'b00, 2'b00);
        chk("c4.s_we", 64'(s_we), 64'h0);
        cyc_vec("c5",  4'b1111, 1'b1, 2'b10, 1'b1, 32'hB0, 2'b10, 2'b00);
        cyc_vec("c6",  4'b0011, 1'b0, 2'b10, 1'b0, 32'h0,  2'b00, 2'b00);
        cyc_vec("c7",  4'b0011, 1'b0, 2'b01, 1'b1, 32'hA4, 2'b00, 2'b00);
        cyc_vec("c8",  4'b0011, 1'b1, 2'b01, 1'b1, 32'hA4, 2'b01, 2'b00);
        cyc_vec("c9",  4'b0000, 1'b0, 2'b01, 1'b0, 32'h0,  2'b00, 2'b00);
        cyc_vec("c10", 4'b0000, 1'b1, 2'b00, 1'b0, 32'h0,  2'b00, 2'b00);

        // Burst: m0 holds cyc for four acked write beats while m1 waits
        m0_adr = 32'h100; m0_we = 1'b1; m0_dat_w = 32'hCAFE_0100;
        cyc_vec("b1",  4'b0011, 1'b0, 2'b00, 1'b0, 32'h0,   2'b00, 2'b00);
        cyc_vec("b2",  4'b1111, 1'b1, 2'b01, 1'b1, 32'h100, 2'b01, 2'b00);
        chk("b2.s_we",    64'(s_we),    64'h1);
        chk("b2.s_dat_w", 64'(s_dat_w), 64'hCAFE_0100);
        m0_adr = 32'h104;
        cyc_vec("b3",  4'b1111, 1'b1, 2'b01, 1'b1, 32'h104, 2'b01, 2'b00);
        m0_adr = 32'h108;
        cyc_vec("b4",  4'b1111, 1'b1, 2'b01, 1'b1, 32'h108, 2'b01, 2'b00);
        m0_adr = 32'h10C;
        cyc_vec("b5",  4'b1111, 1'b1, 2'b01, 1'b1, 32'h10C, 2'b01, 2'b00);
        m0_we  = 1'b0; m0_adr = 32'h0000_00A8;
        cyc_vec("b6",  4'b1100, 1'b0, 2'b01, 1'b0, 32'h0,   2'b00, 2'b00);

        // Timeout: m1 strobes a dead slave, m0 pending; err on 5th stb cycle
        cyc_vec("t1",  4'b1111, 1'b0, 2'b10, 1'b1, 32'hB0, 2'b00, 2'b00);
        cyc_vec("t2",  4'b1111, 1'b0, 2'b10, 1'b1, 32'hB0, 2'b00, 2'b00);
        cyc_vec("t3",  4'b1111, 1'b0, 2'b10, 1'b1, 32'hB0, 2'b00, 2'b00);
        cyc_vec("t4",  4'b1111, 1'b0, 2'b10, 1'b1, 32'hB0, 2'b00, 2'b00);
        cyc_vec("t5",  4'b1111, 1'b0, 2'b10, 1'b0, 32'h0,  2'b00, 2'b10);
        cyc_vec("t6",  4'b0011, 1'b0, 2'b10, 1'b0, 32'h0,  2'b00, 2'b00);
        cyc_vec("t7",  4'b1111, 1'b0, 2'b01, 1'b1, 32'hA8, 2'b00, 2'b00);
        cyc_vec("t8",  4'b1111, 1'b1, 2'b01, 1'b1, 32'hA8, 2'b01, 2'b00);
        cyc_vec("t9",  4'b1100, 1'b0, 2'b01, 1'b0, 32'h0,  2'b00, 2'b00);

        // Ack arrives on the limit cycle: ack wins, counter restarts
        cyc_vec("r1",  4'b1100, 1'b0, 2'b10, 1'b1, 32'hB0, 2'b00, 2'b00);
        cyc_vec("r2",  4'b1100, 1'b0, 2'b10, 1'b1, 32'hB0, 2'b00, 2'b00);
        cyc_vec("r3",  4'b1100, 1'b0, 2'b10, 1'b1, 32'hB0, 2'b00, 2'b00);
        cyc_vec("r4",  4'b1100, 1'b0, 2'b10, 1'b1, 32'hB0, 2'b00, 2'b00);
        cyc_vec("r5",  4'b1100, 1'b1, 2'b10, 1'b1, 32'hB0, 2'b10, 2'b00);
        cyc_vec("r6",  4'b1100, 1'b0, 2'b10, 1'b1, 32'hB0, 2'b00, 2'b00);
        chk("r6.wd_cnt", 64'(dut.wd_cnt), 64'h0);
        cyc_vec("r7",  4'b0011, 1'b0, 2'b10, 1'b0, 32'h0,  2'b00, 2'b00);
        cyc_vec("r8",  4'b0011, 1'b0, 2'b01, 1'b1, 32'hA8, 2'b00, 2'b00);

        // Reset mid-cycle while m0 owns the bus with stb high
        #1;
        HRESETn = 1'b0;
        #1;
        chk("mrst.s_cyc", 64'(s_cyc), 64'h0);
        chk("mrst.s_stb", 64'(s_stb), 64'h0);
        chk("mrst.grant", 64'(grant), 64'h0);
        {m1_cyc, m1_stb} = 2'b11;
        @(negedge HCLK);
        HRESETn = 1'b1;
        #1;
        chk("mrel.grant", 64'(grant), 64'h0);
        cyc_vec("m1",  4'b1111, 1'b0, 2'b01, 1'b1, 32'hA8, 2'b00, 2'b00);
        cyc_vec("m2",  4'b1111, 1'b1, 2'b01, 1'b1, 32'hA8, 2'b01, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
